// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back path.
// Widths mirror the core-wide data_size / regfile_logsize / regfile_size constants.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU,
    SRC_MDU
  } wb_src_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register for outstanding multi-cycle ops.
// A set and a clear of the same register on one edge leaves the bit set.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_rd,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] busy_next;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;  // x0 is never outstanding
  end

  always_ff @(posedge clk) begin
    if (!nrst) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: serialises ALU, LSU and MDU results onto the single
// register-file write port and tracks outstanding multi-cycle destinations.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  busy
);

  // Handshake: LSU/MDU hold valid, rd and data stable until ready; a transfer
  // happens on a posedge with valid & ready. ready is a combinational function
  // of the valids and is forced low while nrst is low. ALU has no backpressure.

  wb_src_t grant;
  wb_src_t last_grant;
  wb_req_t alu_req, lsu_req, mdu_req, win_req;
  logic    contended;
  logic    xfer;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign lsu_req = '{rd: lsu_rd, data: lsu_data};
  assign mdu_req = '{rd: mdu_rd, data: mdu_data};

  assign contended = nrst && !alu_valid && lsu_valid && mdu_valid;

  always_comb begin
    grant   = SRC_NONE;
    win_req = alu_req;
    if (nrst) begin
      if (alu_valid)      grant = SRC_ALU;
      else if (contended) grant = (last_grant == SRC_LSU) ? SRC_MDU : SRC_LSU;
      else if (lsu_valid) grant = SRC_LSU;
      else if (mdu_valid) grant = SRC_MDU;
    end
    case (grant)
      SRC_LSU: win_req = lsu_req;
      SRC_MDU: win_req = mdu_req;
      default: win_req = alu_req;
    endcase
  end

  assign lsu_ready = (grant == SRC_LSU);
  assign mdu_ready = (grant == SRC_MDU);
  assign xfer      = lsu_ready || mdu_ready;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= SRC_MDU;  // LSU wins the first contended cycle
    end else begin
      wr_en <= (grant != SRC_NONE) && (win_req.rd != '0);
      if (grant != SRC_NONE) begin
        wr_addr <= win_req.rd;
        wr_data <= win_req.data;
      end
      if (contended) last_grant <= grant;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk    (clk),
    .nrst   (nrst),
    .set_en (iss_en),
    .set_rd (iss_rd),
    .clr_en (xfer),
    .clr_rd (win_req.rd),
    .busy   (busy)
  );

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side initiator for the integer register file.
- Collects results from the single-cycle ALU, the load/store unit (LSU) and the multi-cycle mul/div unit (MDU), and serialises them onto the register file's single write port (wr_en/wr_addr/wr_data).
- Keeps a pending-write scoreboard for multi-cycle destinations, which the decode stage uses for RAW/WAW stalls.

Parameters:
- DATA_W, `data_size (32): width of result data and of the register-file write data.
- ADDR_W, `regfile_logsize (5): width of a register index.
- NREGS, `regfile_size (32): number of architectural registers; width of the busy vector.

Ports:
- clk  in  1  system clock, posedge.
- nrst  in  1  synchronous reset, active low.
- alu_valid  in  1  ALU result present this cycle; there is no backpressure.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load data.
- mdu_valid  in  1  mul/div result offered.
- mdu_ready  out  1  mul/div result accepted this cycle.
- mdu_rd  in  ADDR_W  mul/div destination register.
- mdu_data  in  DATA_W  mul/div result.
- iss_en  in  1  a multi-cycle op (load or mul/div) is issued this cycle.
- iss_rd  in  ADDR_W  destination register of the issued op.
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- busy  out  NREGS  bit i set means register i has an outstanding multi-cycle write.

Behaviour:
- Reset: on a posedge clk with nrst=0, set wr_en=0, wr_addr=0, wr_data=0, busy=0, and last_grant=MDU (so LSU wins the first contended cycle).
- Handshake: LSU/MDU valid is sticky. rd and data stay stable until ready=1. A transfer occurs on a posedge where valid&ready=1. ready may depend combinationally on valid.
- Grant (combinational):
  - If alu_valid=1, ALU wins and lsu_ready=mdu_ready=0.
  - Else if exactly one of lsu_valid/mdu_valid is 1, that source wins.
  - Else if both are 1, the source not equal to last_grant wins, and last_grant updates to the winner at the edge.
  - last_grant changes only on contended grants.
- Write stage is registered, 1-cycle latency. At the edge after a grant:
  - wr_en=1, wr_addr=winner rd, wr_data=winner data.
  - If winner rd==0, wr_en=0 but the handshake still completes (x0 writes are dropped).
  - If there is no grant, wr_en=0 and wr_addr/wr_data hold their previous values.
- Scoreboard:
  - On an edge with iss_en=1 and iss_rd!=0, set busy[iss_rd].
  - On an edge with an LSU/MDU transfer and rd!=0, clear busy[rd].
  - Same register set and cleared on the same edge: set wins.
  - busy[0] is constant 0.
  - ALU writes never touch busy.
  - busy falls on the same edge that wr_en rises. A dependent read in that cycle is satisfied by the register file's same-cycle write bypass.
- Starvation: continuous alu_valid starves LSU/MDU indefinitely. Decode guarantees ALU bubbles, and the block takes no action.
- Protocol violation: alu_valid with busy[alu_rd]=1 (WAW) is flagged by a bench assertion only. The RTL still performs the write.
- Reset mid-operation: pending handshakes are discarded, busy is cleared, and no write is issued on the edge after reset. Sources must reassert after reset.

Decomposition:
- Constants `data_size, `regfile_logsize and `regfile_size come from constants.sv.
- New package wb_pkg:
  - typedef enum logic[1:0] {SRC_NONE, SRC_ALU, SRC_LSU, SRC_MDU} wb_src_t.
  - typedef struct {logic[ADDR_W-1:0] rd; logic[DATA_W-1:0] data;} wb_req_t.
- One sub-module, wb_scoreboard: the busy vector with set/clear ports and the set-wins rule.
- Arbitration and the write register stay in wb_arbiter.

Test Plan:
- Reset: hold nrst=0 for 2 cycles with all valids=1 → wr_en=0, busy=0, lsu_ready=mdu_ready=0 on every posedge while nrst=0.
- ALU priority: alu_valid=1 (rd=5, data=0xDEADBEEF) with lsu_valid=1 (rd=6) → lsu_ready=0. The next cycle has wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. LSU is accepted the cycle after alu_valid drops, followed by wr_addr=6.
- Round robin: hold lsu_valid and mdu_valid for 4 cycles, no ALU, each source rd different → grant order LSU, MDU, LSU, MDU, with wr_addr following one cycle later.
- Scoreboard: iss_en rd=7 → busy[7]=1. An MDU transfer rd=7 clears busy[7] on the same edge that wr_en=1, wr_addr=7. Issuing rd=7 again on that same edge leaves busy[7]=1.
- x0: LSU transfer with rd=0, data=0x1234 → lsu_ready=1, wr_en stays 0, busy[0]=0. iss_en with rd=0 also leaves busy=0.
- Mid-op reset: busy[3]=1 with mdu_valid pending and nrst pulsed low for one cycle → busy=0, wr_en=0, and no write to register 3 occurs until mdu_valid is reasserted.
